counter_ctrl: RTL

//  Command-side controller for the interval counter.
//  - Accepts START/STOP/CLEAR commands over a valid/ready handshake.
//  - Drives the counter's 8-bit state code and its 32-bit interval.
//  - Reads back the count and halts it at a programmable terminal value.
//  - Sits between the host/button logic and the counter instance.

---
 rtl/counter_ctrl_pkg.sv | 34 +++
 rtl/counter_ctrl_if.sv | 37 +++
 rtl/counter_limit_cmp.sv | 12 +
 rtl/counter_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the interval counter and its command controller:
// state codes on the counter bus, command codes and controller FSM encodings.
package counter_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 32;

    localparam logic [7:0] STATE_RESET = 8'd0;
    localparam logic [7:0] STATE_RUN   = 8'd1;
    localparam logic [7:0] STATE_HALT  = 8'd2;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_START = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        FSM_CLR  = 2'd0,
        FSM_IDLE = 2'd1,
        FSM_RUN  = 2'd2,
        FSM_HALT = 2'd3
    } fsm_e;

    // IDLE and HALT look the same to the counter: both hold the count.
    function automatic logic [7:0] state_code(input fsm_e f);
        case (f)
            FSM_CLR: state_code = STATE_RESET;
            FSM_RUN: state_code = STATE_RUN;
            default: state_code = STATE_HALT;
        endcase
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Command/counter bus between host logic, counter_ctrl and the counter.
// COUNTER_CTRL_AUTORELOAD_EN adds the reloads count.
interface counter_ctrl_if #(parameter int CNT_W = 32);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd;
    logic [CNT_W-1:0] interval_cfg;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] counter;
    logic [7:0]       state;
    logic [CNT_W-1:0] interval;
    logic             busy;
    logic             done;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
    logic [15:0]      reloads;

    modport master (
        output cmd_valid, cmd, interval_cfg, limit, counter,
        input  cmd_ready, state, interval, busy, done, reloads
    );
    modport slave (
        input  cmd_valid, cmd, interval_cfg, limit, counter,
        output cmd_ready, state, interval, busy, done, reloads
    );
`else
    modport master (
        output cmd_valid, cmd, interval_cfg, limit, counter,
        input  cmd_ready, state, interval, busy, done
    );
    modport slave (
        input  cmd_valid, cmd, interval_cfg, limit, counter,
        output cmd_ready, state, interval, busy, done
    );
`endif

endinterface

// File: rtl/counter_limit_cmp.sv
// Terminal-count detector: unsigned full-width compare, limit of zero disables it.
module counter_limit_cmp #(
    parameter int CNT_W = 32
) (
    input  logic [CNT_W-1:0] i_limit,
    input  logic [CNT_W-1:0] i_counter,
    output logic             o_hit
);

    assign o_hit = (i_limit != '0) && (i_counter >= i_limit);

endmodule

// File: rtl/counter_ctrl.sv
// Command-side controller for the interval counter: START/STOP/CLEAR FSM,
// interval latch and done pulse. COUNTER_CTRL_AUTORELOAD_EN restarts after a limit hit.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int CLR_CYCLES = 1,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    counter_ctrl_if.slave  bus
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    fsm_e             r_fsm, w_fsm_next;
    logic [CLR_W-1:0] r_clr_cnt, w_clr_cnt_next;
    logic [7:0]       r_state;
    logic [CNT_W-1:0] r_interval;
    logic             r_busy, r_done, r_cmd_ready;
    logic             w_hit, w_accept, w_done_next, w_load_interval;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
    logic             r_reload, w_reload_next, w_reload_inc;
    logic [15:0]      r_reloads;
`endif

    counter_limit_cmp #(.CNT_W(CNT_W)) u_limit_cmp (
        .i_limit   (bus.limit),
        .i_counter (bus.counter),
        .o_hit     (w_hit)
    );

    assign w_accept = bus.cmd_valid & r_cmd_ready;

    always_comb begin
        w_fsm_next      = r_fsm;
        w_clr_cnt_next  = r_clr_cnt;
        w_done_next     = 1'b0;
        w_load_interval = 1'b0;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
        w_reload_next   = r_reload;
        w_reload_inc    = 1'b0;
`endif
        case (r_fsm)
            FSM_CLR: begin
                if (r_clr_cnt == CLR_LAST) begin
                    w_clr_cnt_next = '0;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                    w_fsm_next    = r_reload ? FSM_RUN : FSM_IDLE;
                    w_reload_next = 1'b0;
`else
                    w_fsm_next    = FSM_IDLE;
`endif
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
            FSM_IDLE: begin
                if (w_accept && bus.cmd == CMD_START) begin
                    w_fsm_next      = FSM_RUN;
                    w_load_interval = 1'b1;
                end else if (w_accept && bus.cmd == CMD_CLEAR) begin
                    w_fsm_next = FSM_CLR;
                end
            end
            FSM_RUN: begin
                // CLEAR beats a limit hit and swallows its done pulse.
                if (w_accept && bus.cmd == CMD_CLEAR) begin
                    w_fsm_next = FSM_CLR;
                end else if (w_hit) begin
                    w_done_next = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                    w_fsm_next    = FSM_CLR;
                    w_reload_next = 1'b1;
                    w_reload_inc  = 1'b1;
`else
                    w_fsm_next    = FSM_HALT;
`endif
                end else if (w_accept && bus.cmd == CMD_STOP) begin
                    w_fsm_next = FSM_HALT;
                end
            end
            FSM_HALT: begin
                if (w_accept && bus.cmd == CMD_CLEAR) begin
                    w_fsm_next = FSM_CLR;
                end else if (w_accept && bus.cmd == CMD_START && !w_hit) begin
                    w_fsm_next = FSM_RUN;
                end
            end
            default: w_fsm_next = FSM_CLR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= FSM_CLR;
            r_clr_cnt   <= '0;
            r_state     <= STATE_RESET;
            r_interval  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_next;
            r_clr_cnt   <= w_clr_cnt_next;
            r_state     <= state_code(w_fsm_next);
            r_busy      <= (w_fsm_next == FSM_RUN);
            r_done      <= w_done_next;
            r_cmd_ready <= (w_fsm_next != FSM_CLR);
            if (w_load_interval) begin
                r_interval <= bus.interval_cfg;
            end
        end
    end

`ifdef COUNTER_CTRL_AUTORELOAD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reload  <= 1'b0;
            r_reloads <= '0;
        end else begin
            r_reload <= w_reload_next;
            if (w_reload_inc) begin
                r_reloads <= r_reloads + 16'd1;
            end
        end
    end

    assign bus.reloads = r_reloads;
`endif

    assign bus.state     = r_state;
    assign bus.interval  = r_interval;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cmd_ready = r_cmd_ready;

endmodule
